cordic_trig: RTL

CORDIC_TRIG -- requirements
Module: cordic_trig

---
 rtl/clbp_pkg.sv | 62 ++++++
 rtl/cordic_trig_if.sv | 25 ++
 rtl/cordic_trig.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/clbp_pkg.sv
// Shared definitions for the CORDIC sine/cosine block: number formats,
// angle constants, arctangent table, rotation gain and the control states.
package clbp_pkg;

    // Angle and result format: signed Q9.16
    localparam int INT_WIDTH  = 9;
    localparam int FRAC_WIDTH = 16;
    localparam int DATA_W     = INT_WIDTH + FRAC_WIDTH;

    // Extra fraction bits carried on x/y so per-iteration shift truncation
    // stays well below one output LSB; removed by rounding at the output.
    localparam int GUARD_W = 4;

    // Internal datapath: two bits of headroom above the port format plus guard
    localparam int DP_W = DATA_W + 2 + GUARD_W;

    // Angle constants (Q.16)
    localparam int HALF_PI_Q16       = 102944;
    localparam int PI_Q16            = 205887;
    localparam int THREE_HALF_PI_Q16 = 308831;
    localparam int TWO_PI_Q16        = 411775;

    // Unit value and CORDIC gain compensation 1/An (Q.16)
    localparam int ONE_Q16 = 65536;
    localparam int K_Q16   = 39797;

    // atan(2^-i) in Q.16 for i = 0..15
    localparam int ATAN_N = 16;
    localparam int ATAN_Q16 [ATAN_N] = '{
        51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
        256,   128,   64,    32,   16,   8,    4,    2
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ROT,
        S_OUT
    } state_t;

    // Arctangent for iteration i; beyond the table the angle step is below one LSB
    function automatic logic signed [DP_W-1:0] atan_at(input int unsigned i);
        if (i < ATAN_N) begin
            return DP_W'(ATAN_Q16[i[3:0]]);
        end
        return '0;
    endfunction

    // Clamp a Q.16 value held in the wide datapath to [-1.0, +1.0]
    function automatic logic signed [DATA_W-1:0] sat_unit(input logic signed [DP_W-1:0] v);
        logic signed [DP_W-1:0] lim;
        lim = DP_W'(ONE_Q16);
        if (v > lim) begin
            return DATA_W'(lim);
        end
        if (v < -lim) begin
            return DATA_W'(-lim);
        end
        return DATA_W'(v);
    endfunction

endpackage

// File: rtl/cordic_trig_if.sv
// Request/result bundle of the CORDIC sine/cosine block.
interface cordic_trig_if;
    import clbp_pkg::*;

    logic signed [DATA_W-1:0] theta;
    logic                     theta_valid;
    logic signed [DATA_W-1:0] cos_data;
    logic                     cos_valid;
    logic signed [DATA_W-1:0] sin_data;
    logic                     sin_valid;
    logic                     busy;

    // Requester side
    modport master (
        output theta, theta_valid,
        input  cos_data, cos_valid, sin_data, sin_valid, busy
    );

    // Block side
    modport slave (
        input  theta, theta_valid,
        output cos_data, cos_valid, sin_data, sin_valid, busy
    );

endinterface

// File: rtl/cordic_trig.sv
// Iterative CORDIC sine/cosine. One request at a time: the angle is folded
// into [-pi/2, pi/2], rotated ITER times through one shared adder set, and the
// rounded, quadrant-corrected, saturated results are presented for one cycle.
module cordic_trig
    import clbp_pkg::*;
#(
    parameter int ITER = 16
) (
    input logic          clk,
    input logic          rst,
    cordic_trig_if.slave bus
);

    localparam int CNT_W = $clog2(ITER + 1);

    localparam logic signed [DP_W-1:0] HALF_PI       = DP_W'(HALF_PI_Q16);
    localparam logic signed [DP_W-1:0] PI            = DP_W'(PI_Q16);
    localparam logic signed [DP_W-1:0] THREE_HALF_PI = DP_W'(THREE_HALF_PI_Q16);
    localparam logic signed [DP_W-1:0] TWO_PI        = DP_W'(TWO_PI_Q16);
    localparam logic signed [DP_W-1:0] K_INIT        = DP_W'(K_Q16) <<< GUARD_W;
    localparam logic signed [DP_W-1:0] ROUND_HALF    = DP_W'(1) <<< (GUARD_W - 1);
    localparam logic [CNT_W-1:0]       LAST_ITER     = CNT_W'(ITER - 1);

    state_t state_q, state_d;

    // Control strobes decoded from the state
    logic accept, load, rotate, emit;
    logic last_iter;

    // Datapath state
    logic signed [DP_W-1:0]   x_q, x_d;
    logic signed [DP_W-1:0]   y_q, y_d;
    logic signed [DP_W-1:0]   z_q, z_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     neg_q, neg_d;
    logic                     zero_q, zero_d;
    logic signed [DATA_W-1:0] cos_q, cos_d;
    logic signed [DATA_W-1:0] sin_q, sin_d;
    logic                     valid_q, valid_d;

    // Combinational helpers
    logic signed [DP_W-1:0] red_angle;
    logic                   red_neg;
    logic signed [DP_W-1:0] x_shift, y_shift, atan_i;
    logic signed [DP_W-1:0] x_rnd, y_rnd;

    assign last_iter = (cnt_q == LAST_ITER);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: single pass IDLE -> PREP -> ROT (ITER cycles) -> OUT
    always_comb begin
        // NOTE: a default before the case keeps this block free of inferred latches.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.theta_valid) state_d = S_PREP;
            S_PREP:  state_d = S_ROT;
            S_ROT:   if (last_iter) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs: requests are only seen while idle, so none are queued
    always_comb begin
        accept = 1'b0;
        load   = 1'b0;
        rotate = 1'b0;
        emit   = 1'b0;
        unique case (state_q)
            S_IDLE:  accept = bus.theta_valid;
            S_PREP:  load   = 1'b1;
            S_ROT:   rotate = 1'b1;
            S_OUT:   emit   = 1'b1;
            default: ;
        endcase
    end

    // Quadrant folding of the captured angle into the CORDIC convergence range
    always_comb begin
        red_angle = z_q;
        red_neg   = 1'b0;
        if (z_q > THREE_HALF_PI) begin
            red_angle = z_q - TWO_PI;
        end else if (z_q > HALF_PI) begin
            red_angle = z_q - PI;
            red_neg   = 1'b1;
        end
    end

    // Output rounding: drop the guard bits with round-half-up
    always_comb begin
        x_rnd = (x_q + ROUND_HALF) >>> GUARD_W;
        y_rnd = (y_q + ROUND_HALF) >>> GUARD_W;
    end

    // Datapath next state: capture, initialise, rotate, then form results
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        cos_d   = '0;
        sin_d   = '0;
        valid_d = 1'b0;

        x_shift = x_q >>> cnt_q;
        y_shift = y_q >>> cnt_q;
        atan_i  = atan_at(32'(cnt_q));

        if (accept) begin
            // z holds the raw angle until the folding step in PREP
            z_d    = {{(DP_W - DATA_W){bus.theta[DATA_W-1]}}, bus.theta};
            zero_d = (bus.theta == '0);
            cnt_d  = '0;
        end

        if (load) begin
            x_d   = K_INIT;
            y_d   = '0;
            z_d   = red_angle;
            neg_d = red_neg;
            cnt_d = '0;
        end

        if (rotate) begin
            // Rotate towards z = 0; a zero residual counts as positive
            if (!z_q[DP_W-1]) begin
                x_d = x_q - y_shift;
                y_d = y_q + x_shift;
                z_d = z_q - atan_i;
            end else begin
                x_d = x_q + y_shift;
                y_d = y_q - x_shift;
                z_d = z_q + atan_i;
            end
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (emit) begin
            valid_d = 1'b1;
            if (zero_q) begin
                cos_d = DATA_W'(ONE_Q16);
                sin_d = '0;
            end else begin
                cos_d = sat_unit(neg_q ? -x_rnd : x_rnd);
                sin_d = sat_unit(neg_q ? -y_rnd : y_rnd);
            end
        end
    end

    // Datapath and result registers; reset also discards any request in flight
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is reset; the atan table is a constant, not a memory, so nothing is left unknown.
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            valid_q <= valid_d;
        end
    end

    assign bus.cos_data  = cos_q;
    assign bus.sin_data  = sin_q;
    assign bus.cos_valid = valid_q;
    assign bus.sin_valid = valid_q;
    // The result cycle is spent back in IDLE, so busy also covers valid
    assign bus.busy      = (state_q != S_IDLE) || valid_q;

endmodule
